if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the PC, drives the
//  word-aligned combinational instruction-memory read port, and registers the
//  returned word into the IF/ID pipeline register with valid, PC and PC+4.
//  Handles ID stall, flush, EX branch/jump redirect and a HALT state. Feeds decode.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  NOP_INSTR   32'h0000_0013  bubble encoding (addi x0,x0,0) placed in IF/ID
// PORTS
//  clk            in   1   single clock, all state on rising edge
//  rst_n          in   1   reset, synchronous, active-low
//  stall_i        in   1   hold PC and IF/ID (load-use hazard from ID)
//  flush_i        in   1   squash IF/ID contents, refetch current PC
//  redirect_i     in   1   taken branch/jump resolved in EX
//  redirect_pc_i  in   32  redirect target
//  halt_i         in   1   enter HALT (e.g. ecall/ebreak decoded)
//  imem_addr_o    out  32  = pc_q (combinational), to instruction memory
//  imem_instr_i   in   32  instruction word returned same cycle (async read)
//  ifid_valid_o   out  1   IF/ID holds a real instruction
//  ifid_pc_o      out  32  PC of IF/ID instruction
//  ifid_pc4_o     out  32  PC+4 of IF/ID instruction
//  ifid_instr_o   out  32  IF/ID instruction (NOP_INSTR when !valid)
//  halted_o       out  1   FSM in HALT
//  misalign_o     out  1   one-cycle pulse: redirect target had [1:0]!=0
//  fetch_count_o  out  32  instructions delivered valid into IF/ID, saturating
// BEHAVIOUR
//  Reset (rst_n=0 at edge): pc_q=RESET_PC, ifid_valid=0, ifid_instr=NOP_INSTR,
//   ifid_pc=ifid_pc4=0, halted=0 (state RUN), misalign=0, fetch_count=0.
//   Reset mid-operation overrides every other input in that cycle.
//  Per-edge priority: reset > redirect > flush > HALT > stall > normal fetch.
//  Normal (RUN, no stall/flush/redirect): IF/ID <= {1, pc_q, pc_q+4, imem_instr_i};
//   pc_q <= pc_q+4; fetch_count++. Latency: addr->IF/ID one cycle.
//  Redirect: pc_q <= {redirect_pc_i[31:2],2'b00}; IF/ID <= bubble (valid=0, NOP,
//   pc fields 0); misalign_o=1 next cycle iff redirect_pc_i[1:0]!=0; wins over
//   simultaneous stall/flush/halt_i; state -> RUN (redirect exits HALT).
//  Flush (no redirect): IF/ID <= bubble; pc_q holds (same PC refetched).
//  Stall (no redirect/flush): pc_q and all IF/ID fields hold; count holds.
//  FSM RUN->HALT when halt_i=1 and no redirect/flush; HALT: pc_q holds, IF/ID
//   <= bubble every cycle, stall_i ignored; HALT->RUN only on redirect or reset.
//  PC arithmetic mod 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.
//  fetch_count saturates at 32'hFFFF_FFFF. misalign_o is 0 in all other cycles.
//  imem_addr_o always word-aligned by construction.
// STRUCTURE
//  Shared package riscv_pkg: XLEN=32, NOP_INSTR, RESET_PC default, ifid_t fields
//   {valid, pc, pc4, instr}.
//  One sub-module: if_id_reg (IF/ID register with hold and bubble-insert controls);
//   PC register, next-PC mux, FSM and counter live in if_stage.
// TESTING
//  Reset then 5 free-run cycles, imem = {00500093,00a00113,002081b3,00302023,
//   00002283} -> IF/ID shows these with pc 0,4,8,C,10; fetch_count=5.
//  stall_i high 2 cycles while IF/ID holds pc=8 -> pc_q=C, IF/ID pc=8 instr
//   002081b3 held; resumes with pc=C next.
//  redirect_i=1, redirect_pc_i=0x40 with stall_i=1 same cycle -> next IF/ID bubble
//   (valid 0, 00000013), pc_q=0x40; following cycle IF/ID pc=0x40 valid.
//  redirect_pc_i=0x42 -> pc_q=0x40, misalign_o pulses exactly one cycle.
//  halt_i=1 -> halted_o=1, bubbles indefinitely, count frozen; redirect to 0x0
//   -> RUN, fetch restarts at 0; rst_n=0 mid-HALT -> all reset values.
//  Redirect to 0xFFFF_FFFC, run 2 cycles -> IF/ID pc FFFF_FFFC then 0000_0000.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: data width, bubble encoding, reset PC
// and the IF/ID pipeline register layout.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RISCV_NOP      = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [XLEN-1:0] RISCV_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
    } ifid_t;

    function automatic ifid_t ifid_bubble(input logic [XLEN-1:0] nop);
        ifid_t b;
        b.valid = 1'b0;
        b.pc    = '0;
        b.pc4   = '0;
        b.instr = nop;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: reset > bubble insert > hold > load.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = RISCV_NOP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hold,
    input  logic            bubble,
    input  logic            valid_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc4_d,
    input  logic [XLEN-1:0] instr_d,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4,
    output logic [XLEN-1:0] instr
);

    ifid_t q;

    // NOTE: sequential state is updated with <= so every register samples the
    // pre-edge value of its inputs, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= ifid_bubble(NOP_INSTR);
        end else if (bubble) begin
            q <= ifid_bubble(NOP_INSTR);
        end else if (!hold) begin
            q.valid <= valid_d;
            q.pc    <= pc_d;
            q.pc4   <= pc4_d;
            q.instr <= instr_d;
        end
    end

    assign valid = q.valid;
    assign pc    = q.pc;
    assign pc4   = q.pc4;
    assign instr = q.instr;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, RUN/HALT control,
// delivered-instruction counter and the IF/ID register instance.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RISCV_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = RISCV_NOP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            halt_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_instr_i,
    output logic            ifid_valid_o,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [XLEN-1:0] ifid_pc4_o,
    output logic [XLEN-1:0] ifid_instr_o,
    output logic            halted_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] fetch_count_o
);

    localparam logic STATE_RUN  = 1'b0;
    localparam logic STATE_HALT = 1'b1;

    logic            state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] count_q;
    logic            count_inc;
    logic            ifid_bubble_en;
    logic            ifid_hold;

    assign pc_plus4 = pc_q + 32'd4;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        misalign_d     = 1'b0;
        count_inc      = 1'b0;
        ifid_bubble_en = 1'b0;
        ifid_hold      = 1'b0;

        if (redirect_i) begin
            pc_d           = {redirect_pc_i[XLEN-1:2], 2'b00};
            misalign_d     = |redirect_pc_i[1:0];
            ifid_bubble_en = 1'b1;
            state_d        = STATE_RUN;
        end else if (flush_i) begin
            ifid_bubble_en = 1'b1;
        end else if (state_q == STATE_HALT || halt_i) begin
            // Entering or sitting in HALT: PC frozen, stall is irrelevant.
            ifid_bubble_en = 1'b1;
            state_d        = STATE_HALT;
        end else if (stall_i) begin
            ifid_hold = 1'b1;
        end else begin
            pc_d      = pc_plus4;
            count_inc = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= STATE_RUN;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            if (count_inc && count_q != '1) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold    (ifid_hold),
        .bubble  (ifid_bubble_en),
        .valid_d (1'b1),
        .pc_d    (pc_q),
        .pc4_d   (pc_plus4),
        .instr_d (imem_instr_i),
        .valid   (ifid_valid_o),
        .pc      (ifid_pc_o),
        .pc4     (ifid_pc4_o),
        .instr   (ifid_instr_o)
    );

    assign imem_addr_o   = pc_q;
    assign halted_o      = state_q;
    assign misalign_o    = misalign_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: the driver queues the expected post-edge
// state for each cycle, a negedge monitor pops and compares it.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, flush_i, redirect_i, halt_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o, imem_instr_i;
    logic        ifid_valid_o, halted_o, misalign_o;
    logic [31:0] ifid_pc_o, ifid_pc4_o, ifid_instr_o, fetch_count_o;

    always #5 clk = ~clk;

    if_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .ifid_valid_o  (ifid_valid_o),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_pc4_o    (ifid_pc4_o),
        .ifid_instr_o  (ifid_instr_o),
        .halted_o      (halted_o),
        .misalign_o    (misalign_o),
        .fetch_count_o (fetch_count_o)
    );

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00a0_0113;
            32'h0000_0008: return 32'h0020_81b3;
            32'h0000_000C: return 32'h0030_2023;
            32'h0000_0010: return 32'h0000_2283;
            default:       return {a[31:2], 2'b11};
        endcase
    endfunction

    always_comb imem_instr_i = imem_word(imem_addr_o);

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_q;
        logic        halted;
        logic        mis;
        logic [31:0] count;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input string field,
                         input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %08h, expected %08h", name, field, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            check(e.name, "valid",  {31'd0, ifid_valid_o}, {31'd0, e.valid});
            check(e.name, "pc",     ifid_pc_o,    e.valid ? e.pc : 32'h0);
            check(e.name, "pc4",    ifid_pc4_o,   e.valid ? e.pc + 32'd4 : 32'h0);
            check(e.name, "instr",  ifid_instr_o, e.valid ? imem_word(e.pc) : 32'h0000_0013);
            check(e.name, "addr",   imem_addr_o,  e.pc_q);
            check(e.name, "halted", {31'd0, halted_o},   {31'd0, e.halted});
            check(e.name, "mis",    {31'd0, misalign_o}, {31'd0, e.mis});
            check(e.name, "count",  fetch_count_o, e.count);
        end
    end

    // One clock with the given inputs, then queue what must be visible after it.
    task automatic cyc(input string name, input logic rn, input logic st, input logic fl,
                       input logic rd, input logic [31:0] rpc, input logic hl,
                       input logic ev, input logic [31:0] epc, input logic [31:0] epcq,
                       input logic eh, input logic em, input logic [31:0] ecnt);
        exp_t e;
        rst_n = rn; stall_i = st; flush_i = fl;
        redirect_i = rd; redirect_pc_i = rpc; halt_i = hl;
        @(posedge clk);
        #1;
        e.name = name; e.valid = ev; e.pc = epc; e.pc_q = epcq;
        e.halted = eh; e.mis = em; e.count = ecnt;
        sb.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = '0; halt_i = 1'b0;

        //   name          rn st fl rd rpc            hl  v  pc             pc_q           h  m  cnt
        cyc("reset",       0, 0, 0, 0, 32'h0,         0,  0, 32'h0,         32'h0,         0, 0, 0);
        cyc("run0",        1, 0, 0, 0, 32'h0,         0,  1, 32'h0,         32'h4,         0, 0, 1);
        cyc("run4",        1, 0, 0, 0, 32'h0,         0,  1, 32'h4,         32'h8,         0, 0, 2);
        cyc("run8",        1, 0, 0, 0, 32'h0,         0,  1, 32'h8,         32'hC,         0, 0, 3);
        cyc("stall1",      1, 1, 0, 0, 32'h0,         0,  1, 32'h8,         32'hC,         0, 0, 3);
        cyc("stall2",      1, 1, 0, 0, 32'h0,         0,  1, 32'h8,         32'hC,         0, 0, 3);
        cyc("runC",        1, 0, 0, 0, 32'h0,         0,  1, 32'hC,         32'h10,        0, 0, 4);
        cyc("run10",       1, 0, 0, 0, 32'h0,         0,  1, 32'h10,        32'h14,        0, 0, 5);
        cyc("redir_stall", 1, 1, 0, 1, 32'h40,        0,  0, 32'h0,         32'h40,        0, 0, 5);
        cyc("run40",       1, 0, 0, 0, 32'h0,         0,  1, 32'h40,        32'h44,        0, 0, 6);
        cyc("flush",       1, 0, 1, 0, 32'h0,         0,  0, 32'h0,         32'h44,        0, 0, 6);
        cyc("refetch44",   1, 0, 0, 0, 32'h0,         0,  1, 32'h44,        32'h48,        0, 0, 7);
        cyc("redir_mis",   1, 0, 0, 1, 32'h42,        0,  0, 32'h0,         32'h40,        0, 1, 7);
        cyc("mis_clear",   1, 0, 0, 0, 32'h0,         0,  1, 32'h40,        32'h44,        0, 0, 8);
        cyc("halt_enter",  1, 1, 0, 0, 32'h0,         1,  0, 32'h0,         32'h44,        1, 0, 8);
        cyc("halt_a",      1, 0, 0, 0, 32'h0,         0,  0, 32'h0,         32'h44,        1, 0, 8);
        cyc("halt_b",      1, 1, 0, 0, 32'h0,         0,  0, 32'h0,         32'h44,        1, 0, 8);
        cyc("halt_c",      1, 0, 0, 0, 32'h0,         0,  0, 32'h0,         32'h44,        1, 0, 8);
        cyc("halt_exit",   1, 0, 0, 1, 32'h0,         1,  0, 32'h0,         32'h0,         0, 0, 8);
        cyc("restart0",    1, 0, 0, 0, 32'h0,         0,  1, 32'h0,         32'h4,         0, 0, 9);
        cyc("halt2",       1, 0, 0, 0, 32'h0,         1,  0, 32'h0,         32'h4,         1, 0, 9);
        cyc("rst_in_halt", 0, 1, 1, 1, 32'h80,        1,  0, 32'h0,         32'h0,         0, 0, 0);
        cyc("redir_top",   1, 0, 0, 1, 32'hFFFF_FFFC, 0,  0, 32'h0,         32'hFFFF_FFFC, 0, 0, 0);
        cyc("run_top",     1, 0, 0, 0, 32'h0,         0,  1, 32'hFFFF_FFFC, 32'h0,         0, 0, 1);
        cyc("run_wrap",    1, 0, 0, 0, 32'h0,         0,  1, 32'h0,         32'h4,         0, 0, 2);
        cyc("flush_halt",  1, 0, 1, 0, 32'h0,         1,  0, 32'h0,         32'h4,         0, 0, 2);
        cyc("run4_again",  1, 0, 0, 0, 32'h0,         0,  1, 32'h4,         32'h8,         0, 0, 3);

        stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; halt_i = 1'b0;
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations never compared, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
